// File: rtl/pwm_capture_pkg.sv
// Shared width default and FSM state encoding for the PWM capture block.
package pwm_capture_pkg;

   localparam int W_DEF = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus rise/fall detection on the synchronized level.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic s_q, s_d;
   logic s_dly_q, s_dly_d;

   always_comb begin
      meta_d  = d_in;
      s_d     = meta_q;
      s_dly_d = s_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q  <= 1'b0;
         s_q     <= 1'b0;
         s_dly_q <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         s_q     <= s_d;
         s_dly_q <= s_dly_d;
      end
   end

   assign s    = s_q;
   assign rise = s_q & ~s_dly_q;
   assign fall = ~s_q & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time of an external PWM line in clock cycles,
// publishing both as a coherent pair, with a stuck-line timeout.
//
// state | meaning
// IDLE  | no reference rise yet (after reset or timeout); edges only restart cnt
// HIGH  | line high, counting high time since the last rise
// LOW   | high time captured, waiting for the rise that closes the period
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int          W              = W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         PWM_IN,
   output logic [W-1:0] PERIOD,
   output logic [W-1:0] DECODE,
   output logic         VALID,
   output logic         DONE,
   output logic         TIMEOUT,
   output logic         LEVEL
);

   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] TO_CNT  = W'(TIMEOUT_CYCLES);

   logic s, rise, fall;

   sync_edge u_sync_edge (
      .clk  (CLK),
      .rst  (RST),
      .d_in (PWM_IN),
      .s    (s),
      .rise (rise),
      .fall (fall)
   );

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] hi_tmp_q, hi_tmp_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] decode_q, decode_d;
   logic         valid_q, valid_d;
   logic         done_q, done_d;
   logic         timeout_q, timeout_d;
   logic         timeout_hit;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_tmp_d  = hi_tmp_q;
      period_d  = period_q;
      decode_d  = decode_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;

      // Any edge in this cycle overrides an expiring timeout.
      timeout_hit = (cnt_q == TO_CNT) && !rise && !fall;

      if (rise || ((state_q == IDLE) && fall)) begin
         cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (rise) state_d = HIGH;
         end
         HIGH: begin
            if (fall) begin
               hi_tmp_d = cnt_q;
               state_d  = LOW;
            end
         end
         LOW: begin
            if (rise) begin
               period_d  = cnt_q;
               decode_d  = hi_tmp_q;
               valid_d   = 1'b1;
               done_d    = 1'b1;
               timeout_d = 1'b0;
               state_d   = HIGH;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         timeout_d = 1'b1;
         valid_d   = 1'b0;
         period_d  = '0;
         decode_d  = '0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_tmp_q  <= '0;
         period_q  <= '0;
         decode_q  <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_tmp_q  <= hi_tmp_d;
         period_q  <= period_d;
         decode_q  <= decode_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   assign PERIOD  = period_q;
   assign DECODE  = decode_q;
   assign VALID   = valid_q;
   assign DONE    = done_q;
   assign TIMEOUT = timeout_q;
   assign LEVEL   = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected (period, high time) pairs are queued at each driven rise
// and matched against every DONE pulse; a second instance with a long timeout covers the 1000/250 loopback.
module tb_pwm_capture;

   localparam int          W    = 28;
   localparam int unsigned TO_A = 100;
   localparam int unsigned TO_B = 5000;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         pwm_a = 1'b0;
   logic         pwm_b = 1'b0;
   logic [W-1:0] period_a, decode_a, period_b, decode_b;
   logic         valid_a, done_a, timeout_a, level_a;
   logic         valid_b, done_b, timeout_b, level_b;

   always #5 clk = ~clk;

   pwm_capture #(.W(W), .TIMEOUT_CYCLES(TO_A)) dut (
      .CLK(clk), .RST(rst), .PWM_IN(pwm_a),
      .PERIOD(period_a), .DECODE(decode_a), .VALID(valid_a),
      .DONE(done_a), .TIMEOUT(timeout_a), .LEVEL(level_a)
   );

   pwm_capture #(.W(W), .TIMEOUT_CYCLES(TO_B)) dut_lb (
      .CLK(clk), .RST(rst), .PWM_IN(pwm_b),
      .PERIOD(period_b), .DECODE(decode_b), .VALID(valid_b),
      .DONE(done_b), .TIMEOUT(timeout_b), .LEVEL(level_b)
   );

   typedef struct packed {
      logic [W-1:0] p;
      logic [W-1:0] d;
   } pair_t;

   pair_t qa[$];
   pair_t qb[$];
   pair_t pend[2];
   bit    pend_valid[2];

   int n_checks   = 0;
   int n_errors   = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   logic         prev_valid_a = 1'b0;
   logic         prev_done_a  = 1'b0;
   logic [W-1:0] prev_p_a     = '0;
   logic [W-1:0] prev_d_a     = '0;

   // Main instance: every DONE must match the oldest queued pair; otherwise a valid pair must hold still.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid_a = 1'b0;
         prev_done_a  = 1'b0;
      end else begin
         if (done_a) begin
            pair_t e;
            done_cnt_a++;
            n_checks++;
            if (prev_done_a) begin
               n_errors++;
               $display("FAIL done_width: DONE high on consecutive cycles at %0t", $time);
            end
            n_checks++;
            if (qa.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_done: got PERIOD=%0d DECODE=%0d, nothing expected", period_a, decode_a);
            end else begin
               e = qa.pop_front();
               if ({period_a, decode_a, valid_a, timeout_a} !== {e.p, e.d, 1'b1, 1'b0}) begin
                  n_errors++;
                  $display("FAIL publish: got P=%0d D=%0d V=%0b T=%0b, want P=%0d D=%0d V=1 T=0",
                           period_a, decode_a, valid_a, timeout_a, e.p, e.d);
               end
            end
         end else if (valid_a && prev_valid_a) begin
            n_checks++;
            if (period_a !== prev_p_a || decode_a !== prev_d_a) begin
               n_errors++;
               $display("FAIL pair_changed: got P=%0d D=%0d without DONE, want P=%0d D=%0d",
                        period_a, decode_a, prev_p_a, prev_d_a);
            end
         end
         prev_valid_a = valid_a;
         prev_done_a  = done_a;
         prev_p_a     = period_a;
         prev_d_a     = decode_a;
      end
   end

   always @(negedge clk) begin
      if (!rst && done_b) begin
         pair_t e;
         done_cnt_b++;
         n_checks++;
         if (qb.size() == 0) begin
            n_errors++;
            $display("FAIL lb_unexpected_done: got PERIOD=%0d DECODE=%0d, nothing expected", period_b, decode_b);
         end else begin
            e = qb.pop_front();
            if ({period_b, decode_b, valid_b, timeout_b} !== {e.p, e.d, 1'b1, 1'b0}) begin
               n_errors++;
               $display("FAIL lb_publish: got P=%0d D=%0d V=%0b T=%0b, want P=%0d D=%0d V=1 T=0",
                        period_b, decode_b, valid_b, timeout_b, e.p, e.d);
            end
         end
      end
   end

   task automatic drive_level(input bit lb, input logic v);
      if (lb) pwm_b = v;
      else    pwm_a = v;
   endtask

   // Each rise closes the previous full period, so it is the moment that period's pair becomes due.
   task automatic drive_periods(input int h, input int l, input int n, input bit lb);
      for (int p = 0; p < n; p++) begin
         if (pend_valid[lb]) begin
            if (lb) qb.push_back(pend[lb]);
            else    qa.push_back(pend[lb]);
         end
         pend[lb].p     = W'(h + l);
         pend[lb].d     = W'(h);
         pend_valid[lb] = 1'b1;
         for (int i = 0; i < h; i++) begin
            drive_level(lb, 1'b1);
            @(negedge clk);
         end
         for (int i = 0; i < l; i++) begin
            drive_level(lb, 1'b0);
            @(negedge clk);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      pwm_a = 1'b0;
      pwm_b = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      qa.delete();
      qb.delete();
      pend_valid[0] = 1'b0;
      pend_valid[1] = 1'b0;
      done_cnt_a    = 0;
      done_cnt_b    = 0;
      @(negedge clk);
   endtask

   task automatic drain(input bit lb, input string name);
      repeat (6) @(negedge clk);
      n_checks++;
      if ((lb ? qb.size() : qa.size()) != 0) begin
         n_errors++;
         $display("FAIL %s_missing_done: %0d results still expected, want 0", name, lb ? qb.size() : qa.size());
      end
   endtask

   task automatic check_done_count(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s_done_count: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (period_a !== '0)  begin n_errors++; $display("FAIL rst_period: got %0d, want 0", period_a); end
      n_checks++; if (decode_a !== '0)  begin n_errors++; $display("FAIL rst_decode: got %0d, want 0", decode_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b, want 0", valid_a); end
      n_checks++; if (done_a !== 1'b0)  begin n_errors++; $display("FAIL rst_done: got %0b, want 0", done_a); end
      n_checks++; if (timeout_a !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %0b, want 0", timeout_a); end
      n_checks++; if (level_a !== 1'b0) begin n_errors++; $display("FAIL rst_level: got %0b, want 0", level_a); end
      rst = 1'b0;
   endtask

   task automatic test_periodic();
      do_reset();
      drive_periods(10, 30, 1, 1'b0);
      n_checks++;
      if (valid_a !== 1'b0 || done_cnt_a != 0) begin
         n_errors++;
         $display("FAIL periodic_first_rise: got VALID=%0b dones=%0d, want VALID=0 dones=0", valid_a, done_cnt_a);
      end
      drive_periods(10, 30, 5, 1'b0);
      drain(1'b0, "periodic");
      check_done_count("periodic", done_cnt_a, 5);
   endtask

   task automatic test_min_waveform();
      do_reset();
      drive_periods(1, 1, 8, 1'b0);
      drain(1'b0, "min");
      check_done_count("min", done_cnt_a, 7);
   endtask

   task automatic test_timeout();
      do_reset();
      drive_periods(10, 10, 3, 1'b0);
      // Final rise publishes the last 10/10 period, then the line sticks high.
      qa.push_back(pend[0]);
      pend_valid[0] = 1'b0;
      pwm_a = 1'b1;
      repeat (102) @(posedge clk);
      #1;
      n_checks++;
      if (timeout_a !== 1'b0 || valid_a !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_early: got TIMEOUT=%0b VALID=%0b, want TIMEOUT=0 VALID=1", timeout_a, valid_a);
      end
      @(posedge clk);
      #1;
      n_checks++; if (timeout_a !== 1'b1) begin n_errors++; $display("FAIL timeout_flag: got %0b, want 1", timeout_a); end
      n_checks++; if (valid_a !== 1'b0)   begin n_errors++; $display("FAIL timeout_valid: got %0b, want 0", valid_a); end
      n_checks++; if (period_a !== '0)    begin n_errors++; $display("FAIL timeout_period: got %0d, want 0", period_a); end
      n_checks++; if (decode_a !== '0)    begin n_errors++; $display("FAIL timeout_decode: got %0d, want 0", decode_a); end
      n_checks++; if (level_a !== 1'b1)   begin n_errors++; $display("FAIL timeout_level: got %0b, want 1", level_a); end
      n_checks++; if (qa.size() != 0)     begin n_errors++; $display("FAIL timeout_pending: got %0d queued, want 0", qa.size()); end
      @(negedge clk);
      pwm_a = 1'b0;
      repeat (20) @(negedge clk);
      drive_periods(20, 20, 1, 1'b0);
      n_checks++;
      if (timeout_a !== 1'b1 || valid_a !== 1'b0) begin
         n_errors++;
         $display("FAIL restart_first_rise: got TIMEOUT=%0b VALID=%0b, want TIMEOUT=1 VALID=0", timeout_a, valid_a);
      end
      drive_periods(20, 20, 2, 1'b0);
      drain(1'b0, "restart");
      n_checks++;
      if (timeout_a !== 1'b0 || period_a !== W'(40) || decode_a !== W'(20)) begin
         n_errors++;
         $display("FAIL restart_result: got T=%0b P=%0d D=%0d, want T=0 P=40 D=20", timeout_a, period_a, decode_a);
      end
   endtask

   task automatic test_duty_change();
      do_reset();
      drive_periods(5, 15, 4, 1'b0);
      drive_periods(12, 8, 4, 1'b0);
      drain(1'b0, "duty");
      check_done_count("duty", done_cnt_a, 7);
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_periods(10, 10, 3, 1'b0);
      qa.push_back(pend[0]);
      pend_valid[0] = 1'b0;
      pwm_a = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (valid_a !== 1'b1 || qa.size() != 0) begin
         n_errors++;
         $display("FAIL midrst_before: got VALID=%0b queued=%0d, want VALID=1 queued=0", valid_a, qa.size());
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({period_a, decode_a, valid_a, done_a, timeout_a, level_a} !== '0) begin
         n_errors++;
         $display("FAIL midrst_async: got P=%0d D=%0d V=%0b DN=%0b T=%0b L=%0b, want all 0",
                  period_a, decode_a, valid_a, done_a, timeout_a, level_a);
      end
      pwm_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      qa.delete();
      done_cnt_a = 0;
      repeat (3) @(negedge clk);
      drive_periods(10, 10, 1, 1'b0);
      n_checks++;
      if (valid_a !== 1'b0 || done_cnt_a != 0) begin
         n_errors++;
         $display("FAIL midrst_first_rise: got VALID=%0b dones=%0d, want VALID=0 dones=0", valid_a, done_cnt_a);
      end
      drive_periods(10, 10, 2, 1'b0);
      drain(1'b0, "midrst");
      check_done_count("midrst", done_cnt_a, 2);
   endtask

   task automatic test_loopback();
      do_reset();
      drive_periods(250, 750, 3, 1'b1);
      drain(1'b1, "loopback");
      check_done_count("loopback", done_cnt_b, 2);
      n_checks++;
      if (level_b !== 1'b0 || period_b !== W'(1000) || decode_b !== W'(250)) begin
         n_errors++;
         $display("FAIL loopback_hold: got L=%0b P=%0d D=%0d, want L=0 P=1000 D=250", level_b, period_b, decode_b);
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_min_waveform();
      test_timeout();
      test_duty_change();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM measurement block: the input-side counterpart of the per-channel PWM generators on the Nios II board. It samples one external PWM line, measures the period and high time in `CLK` cycles, and publishes them as a coherent pair on two 28-bit buses for Nios PIO input ports. A signal produced by a generator with Period = P and Decode = D reads back as `PERIOD` = P and `DECODE` = D. A stuck line is reported through a timeout flag.

## Interface
- `W`, 28: counter and result width; matches the generator's Period/Decode width.
- `TIMEOUT_CYCLES`, 50_000_000: cycles without a qualifying edge before the line is declared stuck (1 s at 50 MHz); must satisfy 2 ≤ value < 2^W.

- `CLK` in 1: single clock.
- `RST` in 1: reset; asynchronous, active-high.
- `PWM_IN` in 1: external PWM line, asynchronous to `CLK`.
- `PERIOD` out W: last measured period in cycles (rise to rise).
- `DECODE` out W: high time in cycles belonging to the same period as `PERIOD`.
- `VALID` out 1: `PERIOD`/`DECODE` hold a complete measurement.
- `DONE` out 1: one-cycle pulse on each `PERIOD`/`DECODE` update.
- `TIMEOUT` out 1: no edge seen for `TIMEOUT_CYCLES`; line is stuck.
- `LEVEL` out 1: synchronized line level.

## Operation
- Synchronizer: 2-FF on `PWM_IN` gives `s`, plus delayed copy `s_d`.
  - rise = `s` & ~`s_d`; fall = ~`s` & `s_d`.
  - `LEVEL` = `s`.
- Counter `cnt` (W bits): loads 1 on rise; otherwise increments, saturating at 2^W−1.
- States:
  - IDLE: waits for rise, ignores fall; on rise → HIGH.
  - HIGH: on fall, `hi_tmp` ← `cnt` → LOW.
  - LOW: on rise, `PERIOD` ← `cnt`, `DECODE` ← `hi_tmp`, `VALID` ← 1, `DONE` pulses, `TIMEOUT` ← 0 → HIGH.
- Rise in HIGH cannot occur (edges alternate); no special handling is required.
- The first partial period after reset or timeout is discarded. `VALID` first asserts at the second rise.
- Timeout: in any state, when `cnt` = `TIMEOUT_CYCLES` with no rise or fall in that cycle:
  - `TIMEOUT` ← 1, `VALID` ← 0, `PERIOD` ← 0, `DECODE` ← 0 → IDLE.
  - `cnt` keeps counting/saturating and does not re-trigger; software reads `LEVEL` for 0 % or 100 %.
- In IDLE, reset `cnt` to 1 on every edge, so the timeout measures time since the last edge.
- Simultaneous timeout and edge in one cycle: the edge wins.
- Minimum measurable signal: 1 high and 1 low cycle, giving `PERIOD` = 2, `DECODE` = 1.
- Generator settings Decode = 0 or Decode ≥ Period produce a constant line, which is reported as timeout.

## Timing
- Reset values: `PERIOD` = 0, `DECODE` = 0, `VALID` = 0, `DONE` = 0, `TIMEOUT` = 0, `LEVEL` = 0. Also sync FFs = 0, `cnt` = 0, `hi_tmp` = 0, state IDLE.
- `RST` mid-measurement aborts it with no partial publish.
- Latency: if a `PWM_IN` rise is first sampled at clock edge k, results and `DONE` are visible after edge k+2.
- `PERIOD`, `DECODE` and `VALID` change only on the same edge, so the pair is always coherent.
- `DONE` is exactly one cycle wide and is registered.
- All outputs are registered; there are no combinational paths from `PWM_IN`.
- Width: `cnt` compare against `TIMEOUT_CYCLES` uses W bits.

## Structure
- Package `pwm_capture_pkg`: `W` default and state enum {IDLE, HIGH, LOW}.
- Sub-module `sync_edge`: 2-FF synchronizer plus edge detector; outputs `s`, rise and fall.
- Top level holds the counter, FSM and result registers.

## Test plan
- Periodic input, 10 cycles high / 30 cycles low, phase-locked to `CLK`:
  - second rise → `PERIOD` = 40, `DECODE` = 10, `VALID` = 1, one `DONE` per period.
- Minimum waveform, alternating 1/0 every cycle:
  - `PERIOD` = 2, `DECODE` = 1 on every `DONE`.
- Line stuck high, with `TIMEOUT_CYCLES` = 100:
  - 100 cycles after the last edge → `TIMEOUT` = 1, `VALID` = 0, `PERIOD` = `DECODE` = 0, `LEVEL` = 1.
  - Restart 20/20 → `TIMEOUT` = 0 and `PERIOD` = 40 at the second rise.
- Duty change mid-stream, from 5/15 to 12/8:
  - outputs step from (20, 5) directly to (20, 12); no mixed pair on any cycle.
- Assert `RST` while in HIGH:
  - all outputs return to 0 asynchronously.
  - After release, the first published result appears only at the second rise.
- Loopback from a generator configured with Period = 1000, Decode = 250:
  - `PERIOD` = 1000, `DECODE` = 250 on every update.
